// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Serial receive front-end. The asynchronous rx line is synchronised,
//   oversampled by a down-counting bit timer and deframed (8N1, LSB first,
//   or 8E1 when UART_RX_PARITY_EN is defined). Good bytes are pushed into a
//   show-ahead FIFO whose head is always presented on rd_data.
//
// Configuration macro
//   UART_RX_PARITY_EN : when defined, an even-parity bit follows the data
//                       bits; a parity mismatch is reported as frame_err.
//
// Parameters
//   CLK_DIV : clk cycles per serial bit (>= 4)
//   AW      : FIFO address width, depth = 2**AW
//
// Ports
//   clk       in   system clock (posedge)
//   rst       in   asynchronous reset, active-high
//   rx        in   serial line, asynchronous, idle high
//   rd_en     in   pop head byte (ignored while empty)
//   rd_data   out  FIFO head byte, valid while empty==0
//   empty     out  FIFO holds no bytes
//   full      out  FIFO holds 2**AW bytes
//   count     out  bytes currently stored (0..2**AW)
//   frame_err out  1-cycle pulse: bad stop bit (or bad parity)
//   overflow  out  1-cycle pulse: good byte dropped because FIFO full
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_DIV = 434,
    parameter int AW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          frame_err,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(CLK_DIV);

    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [AW-1:0] PTR_ZERO    = AW'(0);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW:0]   CNT_ZERO    = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL    = (AW+1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`endif

    // Registered state
    logic            rx_meta_q, rx_meta_d;
    logic            rxs_q,     rxs_d;
    state_t          state_q,   state_d;
    logic [TW-1:0]   timer_q,   timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q,   shift_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
`endif
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [AW:0]     count_q,   count_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            empty_q,   empty_d;
    logic            full_q,    full_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q,  overflow_d;

    // Combinational helpers
    logic            tick_s;
    logic            push_s;
    logic            pop_s;

    // Next-state logic: synchroniser, bit timer, deframing FSM and FIFO
    always_comb begin
        rx_meta_d   = rx;
        rxs_d       = rx_meta_q;
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
`endif
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        push_s      = 1'b0;

        tick_s = (timer_q == TIMER_ZERO);
        // Timer free-runs down and parks at zero; states reload it as needed.
        if (tick_s) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q - TIMER_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    // Half a bit period lands the next tick mid start bit.
                    timer_d = HALF_RELOAD;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (!rxs_q) begin
                        timer_d   = BIT_RELOAD;
                        bit_idx_d = 3'd0;
                        state_d   = ST_DATA;
                    end else begin
                        // Line returned high: a glitch, silently ignored.
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_d[bit_idx_q] = rxs_q;
                    timer_d            = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    par_bit_d = rxs_q;
                    timer_d   = BIT_RELOAD;
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    if (rxs_q) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bit_q != (^shift_q)) begin
                            frame_err_d = 1'b1;
                        end else if (!full_q || rd_en) begin
                            push_s = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
`else
                        // A pop in the same cycle frees the slot for this byte.
                        if (!full_q || rd_en) begin
                            push_s = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                // Held-low line: stay here so only one frame_err is reported.
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // FIFO update
        pop_s    = rd_en && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Head is computed from the next memory image so a push into an
        // emptying FIFO is visible the very next cycle.
        rd_data_d = mem_d[rd_ptr_d];
        empty_d   = (count_d == CNT_ZERO);
        full_d    = (count_d == CNT_FULL);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= TIMER_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            rd_data_q   <= 8'h00;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= par_bit_d;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo (CLK_DIV=8, AW=2). A table of
//   frames with hand-computed FIFO expectations is applied in a loop, then
//   hand-written sequences cover glitch rejection, a held-low break, and
//   reset in the middle of a frame.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CLK_DIV = 8;
    localparam int AW      = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          frame_err;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    logic [7:0] model_q [$];

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Pulse counters for frame_err / overflow, sampled away from the edge
    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overflow)  ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Send one frame starting at a negedge; samples the FIFO one cycle
    // before and one cycle after the stop-bit tick. Ends at a negedge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic pop_at_stop, input logic bad_par,
                              input int gap,
                              output int pre_cnt, output logic pre_empty,
                              output int post_cnt, output logic [7:0] post_head,
                              output logic post_full, output logic post_empty);
        logic [10:0] bits;
        int nb;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^data) ^ bad_par;
        bits[10] = stop_bit;
        nb = 11;
`else
        bits[9] = stop_bit;
        nb = 10;
`endif
        pre_cnt = 0; pre_empty = 1'b0; post_cnt = 0;
        post_head = 8'h00; post_full = 1'b0; post_empty = 1'b0;
        for (int b = 0; b < nb; b++) begin
            rx = bits[b];
            for (int w = 1; w <= CLK_DIV; w++) begin
                @(negedge clk);
                if (b == nb - 1 && w == 6) begin
                    pre_cnt   = int'(count);
                    pre_empty = empty;
                    if (pop_at_stop) rd_en = 1'b1;
                end
                if (b == nb - 1 && w == 7) begin
                    rd_en      = 1'b0;
                    post_cnt   = int'(count);
                    post_head  = rd_data;
                    post_full  = full;
                    post_empty = empty;
                end
            end
        end
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Pop every byte the model holds, checking order, then check empty.
    task automatic drain();
        while (model_q.size() > 0) begin
            check("drain_head", {24'h0, rd_data}, {24'h0, model_q[0]});
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            void'(model_q.pop_front());
        end
        check("drain_empty", {31'h0, empty}, 32'd1);
        check("drain_count", {29'h0, count}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pop;
        logic       drain;
        int         pre_cnt;
        int         cnt;
        logic [7:0] head;
        int         fe;
        int         ov;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int pc, qc, fe0, ov0;
        logic pe, pf, pem;
        logic [7:0] ph;

        // data  stop pop drain pre cnt head fe ov
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 0, 1, 8'h55, 0, 0};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1, 2, 8'h55, 0, 0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 2, 2, 8'h55, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 0, 1, 8'h01, 0, 0};
        vecs[4] = '{8'h02, 1'b1, 1'b0, 1'b0, 1, 2, 8'h01, 0, 0};
        vecs[5] = '{8'h03, 1'b1, 1'b0, 1'b0, 2, 3, 8'h01, 0, 0};
        vecs[6] = '{8'h04, 1'b1, 1'b0, 1'b0, 3, 4, 8'h01, 0, 0};
        vecs[7] = '{8'h05, 1'b1, 1'b0, 1'b0, 4, 4, 8'h01, 0, 1};
        vecs[8] = '{8'h06, 1'b1, 1'b1, 1'b0, 4, 4, 8'h02, 0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rd_data",   {24'h0, rd_data},   32'd0);
        check("rst_empty",     {31'h0, empty},     32'd1);
        check("rst_full",      {31'h0, full},      32'd0);
        check("rst_count",     {29'h0, count},     32'd0);
        check("rst_frame_err", {31'h0, frame_err}, 32'd0);
        check("rst_overflow",  {31'h0, overflow},  32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table of frames
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].drain) drain();
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].pop, 1'b0, 16,
                       pc, pe, qc, ph, pf, pem);
            check($sformatf("v%0d_pre_count", i), pc, vecs[i].pre_cnt);
            check($sformatf("v%0d_pre_empty", i), {31'h0, pe}, (vecs[i].pre_cnt == 0) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_count", i), qc, vecs[i].cnt);
            check($sformatf("v%0d_head", i), {24'h0, ph}, {24'h0, vecs[i].head});
            check($sformatf("v%0d_full", i), {31'h0, pf}, (vecs[i].cnt == 4) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_empty", i), {31'h0, pem}, 32'd0);
            check($sformatf("v%0d_frame_err", i), fe_cnt - fe0, vecs[i].fe);
            check($sformatf("v%0d_overflow", i), ov_cnt - ov0, vecs[i].ov);
            if (vecs[i].pop && model_q.size() > 0) void'(model_q.pop_front());
            if (vecs[i].fe == 0 && vecs[i].ov == 0) model_q.push_back(vecs[i].data);
        end
        drain();

        // Bad stop bit followed by a long low line: one frame_err only
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, pc, pe, qc, ph, pf, pem);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        check("break_frame_err", fe_cnt - fe0, 1);
        check("break_count", {29'h0, count}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 16, pc, pe, qc, ph, pf, pem);
        check("after_break_count", qc, 1);
        check("after_break_head", {24'h0, ph}, 32'h81);
        model_q.push_back(8'h81);
        drain();

        // Two-cycle glitch on the idle line
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_count", {29'h0, count}, 32'd0);
        check("glitch_frame_err", fe_cnt - fe0, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 16, pc, pe, qc, ph, pf, pem);
        check("after_glitch_count", qc, 1);
        check("after_glitch_head", {24'h0, ph}, 32'h5A);

        // Reset in the middle of receiving 0xFF (0x5A still buffered)
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("pre_rst_count", {29'h0, count}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_count",   {29'h0, count},   32'd0);
        check("mid_rst_empty",   {31'h0, empty},   32'd1);
        check("mid_rst_rd_data", {24'h0, rd_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        fe0 = fe_cnt;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h12, 1'b1, 1'b0, 1'b1, 16, pc, pe, qc, ph, pf, pem);
        check("post_rst_parity_frame_err", fe_cnt - fe0, 1);
        check("post_rst_parity_count", qc, 0);
        repeat (100) @(negedge clk);
        check("post_rst_parity_count_late", {29'h0, count}, 32'd0);
`else
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 16, pc, pe, qc, ph, pf, pem);
        check("post_rst_pre_count", pc, 0);
        check("post_rst_count", qc, 1);
        check("post_rst_head", {24'h0, ph}, 32'h12);
        check("post_rst_frame_err", fe_cnt - fe0, 0);
        repeat (100) @(negedge clk);
        check("post_rst_count_late", {29'h0, count}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
